lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control stage sitting directly upstream of the data memory (DMEM) in the core's memory stage. It accepts one load or store request at a time from the execute/memory pipeline over a valid/ready handshake and range/size/alignment-checks it. Legal requests become a single-cycle DMEM strobe; for loads, the registered DMEM read data is captured and returned on a valid/ready response channel with an error code.

## Interface
Parameters:
- ADDR_W, 14: DMEM byte-address width; request address bits [31:ADDR_W] must be zero.

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST_N  in  1  reset; synchronous, active-low
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  request accepted when VALID&&READY at a rising edge
- REQ_WE  in  1  1 = store, 0 = load
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
- REQ_SIGN  in  1  load sign-extend (1) / zero-extend (0); ignored for stores
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data, LSB-aligned
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response consumed when VALID&&READY at a rising edge
- RSP_RDATA  out  32  load data (already extended by DMEM); 0 for stores and faults
- RSP_ERR  out  2  00 ok, 01 misaligned, 10 out-of-range, 11 illegal size
- DMEM_RDEN  out  1  DMEM read strobe
- DMEM_WEN  out  1  DMEM write strobe
- DMEM_BYTE_SEL  out  2  size to DMEM, same encoding as REQ_SIZE
- DMEM_SIGN  out  1  extension select to DMEM
- DMEM_ADDR  out  ADDR_W  byte address to DMEM
- DMEM_WDATA  out  32  write data to DMEM
- DMEM_RDATA  in  32  DMEM read data; valid in the cycle after the edge that sampled DMEM_RDEN=1

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- IDLE: REQ_READY=1 (forced 0 while RST_N=0). On accept, register WE/SIZE/SIGN/ADDR/WDATA and evaluate fault, priority illegal size > out-of-range > misaligned.
  - Fault: -> RESP with RSP_ERR set, RSP_RDATA=0; no DMEM strobe ever issued.
  - Legal: -> ISSUE.
- ISSUE: drive DMEM_RDEN=!WE, DMEM_WEN=WE for exactly this one cycle, plus BYTE_SEL/SIGN/ADDR[ADDR_W-1:0]/WDATA from registers. Store -> RESP (RSP_ERR=00, RSP_RDATA=0). Load -> WAIT.
- WAIT: capture DMEM_RDATA into RSP_RDATA at end of cycle -> RESP.
- RESP: RSP_VALID=1; RSP_RDATA/RSP_ERR held stable until RSP_READY; on handshake -> IDLE. REQ_READY=0 in all non-IDLE states (one outstanding request).
- Misaligned: half with ADDR[0]=1; word with ADDR[1:0]!=00. Byte never misaligned.
- DMEM strobes are 0 in every state except ISSUE; DMEM_ADDR/WDATA/BYTE_SEL/SIGN hold their last values outside ISSUE.

## Timing
- Reset (RST_N=0 sampled): state=IDLE; REQ_READY=0 during reset; RSP_VALID=0, RSP_RDATA=0, RSP_ERR=00, DMEM_RDEN=0, DMEM_WEN=0, DMEM_BYTE_SEL=00, DMEM_SIGN=0, DMEM_ADDR=0, DMEM_WDATA=0.
- Accept at edge T: strobe in cycle T..T+1 (sampled by DMEM at T+1).
- Store: RSP_VALID high from edge T+2. Load: RSP_VALID high from edge T+3. Fault: RSP_VALID high from edge T+1.
- RSP_READY already high: response lasts one cycle; next REQ_READY=1 immediately after.
- RSP_READY low: stall in RESP indefinitely, outputs stable, no new DMEM strobes.
- Reset mid-operation: at the sampled edge all strobes drop and the pending request/response is discarded; no response is produced for it.
- REQ_* ignored outside IDLE; changes to REQ_* after acceptance have no effect.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned requests fault with RSP_ERR=01, no DMEM access.
- Undefined: no misalignment fault; DMEM_ADDR low bits forced to zero (half clears bit0, word clears bits[1:0]) and the access proceeds normally with RSP_ERR=00. Size and range checks are unaffected.

## Test plan
- Reset: hold RST_N=0 3 cycles -> all outputs at reset values, REQ_READY=0; release -> REQ_READY=1.
- Store word 0xdeadbeef to 0x0, then load word 0x0 with RSP_READY=1 -> one DMEM_WEN pulse (BYTE_SEL=10, ADDR=0), store RSP at T+2, ERR=00; load RSP_RDATA=0xdeadbeef at T+3.
- Load half SIGN=1 from 0x8 with DMEM returning 0xffffbeef, RSP_READY low 4 cycles -> RSP_VALID held 4+ cycles, RSP_RDATA=0xffffbeef stable, no extra strobes.
- Word load at 0x1: with LSU_MISALIGN_TRAP_EN -> RSP_ERR=01 at T+1, no strobes; without -> DMEM_ADDR=0x0, RSP_ERR=00.
- REQ_ADDR=0x0000_4000 with REQ_SIZE=11 -> RSP_ERR=11 (size wins); REQ_ADDR=0x0000_4000 word -> RSP_ERR=10; no DMEM strobes in either.
- Assert RST_N=0 in WAIT -> no RSP_VALID, strobes 0, IDLE after release.

Source files
------------

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
//
// Load/store control stage in front of the data memory (DMEM). It accepts one
// load or store request at a time on a valid/ready channel and checks its
// size, range and alignment. A legal request becomes a single-cycle DMEM read
// or write strobe. The result is returned on a valid/ready response channel
// as read data plus an error code. Only one request is in flight at a time:
// REQ_READY is low from acceptance until the response handshake completes.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   : misaligned half/word requests fault with
//                                     RSP_ERR=01 and never reach DMEM.
//                         undefined : misaligned requests are not faulted. The
//                                     low address bits are cleared (half: bit 0,
//                                     word: bits [1:0]) and the access proceeds.
//
// Parameters:
//   ADDR_W         DMEM byte-address width. REQ_ADDR[31:ADDR_W] must be zero.
//
// Ports:
//   CLK            clock; all logic runs on the rising edge
//   RST_N          synchronous active-low reset
//   REQ_VALID      request valid
//   REQ_READY      request ready (high only in IDLE and out of reset)
//   REQ_WE         1 = store, 0 = load
//   REQ_SIZE       00 byte, 01 half, 10 word, 11 illegal
//   REQ_SIGN       load sign-extend select (passed through to DMEM)
//   REQ_ADDR       byte address
//   REQ_WDATA      store data, LSB-aligned
//   RSP_VALID      response valid
//   RSP_READY      response ready
//   RSP_RDATA      load data; 0 for stores and faults
//   RSP_ERR        00 ok, 01 misaligned, 10 out-of-range, 11 illegal size
//   DMEM_RDEN      DMEM read strobe (one cycle)
//   DMEM_WEN       DMEM write strobe (one cycle)
//   DMEM_BYTE_SEL  access size to DMEM, encoded as REQ_SIZE
//   DMEM_SIGN      extension select to DMEM
//   DMEM_ADDR      byte address to DMEM
//   DMEM_WDATA     write data to DMEM
//   DMEM_RDATA     DMEM read data, valid the cycle after the RDEN strobe
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_SIGN,
  input  logic [31:0]       REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_RDATA,
  output logic [1:0]        RSP_ERR,
  output logic              DMEM_RDEN,
  output logic              DMEM_WEN,
  output logic [1:0]        DMEM_BYTE_SEL,
  output logic              DMEM_SIGN,
  output logic [ADDR_W-1:0] DMEM_ADDR,
  output logic [31:0]       DMEM_WDATA,
  input  logic [31:0]       DMEM_RDATA
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_MIS   = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_SIZE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t              state_reg;
  logic                we_reg;
  logic                rsp_valid_reg;
  logic [31:0]         rsp_rdata_reg;
  logic [1:0]          rsp_err_reg;
  logic                dmem_rden_reg;
  logic                dmem_wen_reg;
  logic [1:0]          dmem_byte_sel_reg;
  logic                dmem_sign_reg;
  logic [ADDR_W-1:0]   dmem_addr_reg;
  logic [31:0]         dmem_wdata_reg;

  logic                range_bad;
  logic [1:0]          fault_code;
  logic [ADDR_W-1:0]   addr_issue;

  // ---------------------------------------------------------------------------
  // Request checks (evaluated on the live request; only used at acceptance)
  // ---------------------------------------------------------------------------

  // Any set bit above the DMEM window is out of range. With a full 32-bit
  // window there is nothing to check.
  generate
    if (ADDR_W < 32) begin : g_range
      assign range_bad = |REQ_ADDR[31:ADDR_W];
    end else begin : g_no_range
      assign range_bad = 1'b0;
    end
  endgenerate

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((REQ_SIZE == SZ_HALF) && REQ_ADDR[0]) ||
                      ((REQ_SIZE == SZ_WORD) && (REQ_ADDR[1:0] != 2'b00));
`endif

  // Priority: illegal size, then out-of-range, then misalignment.
  always_comb begin
    fault_code = ERR_OK;
    if (REQ_SIZE == SZ_ILL) begin
      fault_code = ERR_SIZE;
    end else if (range_bad) begin
      fault_code = ERR_RANGE;
`ifdef LSU_MISALIGN_TRAP_EN
    end else if (misaligned) begin
      fault_code = ERR_MIS;
`endif
    end
  end

  // Address presented to DMEM. When misalignment is not trapped, it is
  // silently rounded down to the natural boundary of the access size.
  always_comb begin
    addr_issue = REQ_ADDR[ADDR_W-1:0];
`ifndef LSU_MISALIGN_TRAP_EN
    if (REQ_SIZE == SZ_HALF) begin
      addr_issue[0] = 1'b0;
    end else if (REQ_SIZE == SZ_WORD) begin
      addr_issue[1:0] = 2'b00;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg         <= IDLE;
      we_reg            <= 1'b0;
      rsp_valid_reg     <= 1'b0;
      rsp_rdata_reg     <= '0;
      rsp_err_reg       <= ERR_OK;
      dmem_rden_reg     <= 1'b0;
      dmem_wen_reg      <= 1'b0;
      dmem_byte_sel_reg <= SZ_BYTE;
      dmem_sign_reg     <= 1'b0;
      dmem_addr_reg     <= '0;
      dmem_wdata_reg    <= '0;
    end else begin
      // Strobes are single-cycle: they are raised only on the transition
      // into ISSUE and fall back on the next edge.
      dmem_rden_reg <= 1'b0;
      dmem_wen_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (REQ_VALID) begin
            we_reg <= REQ_WE;
            if (fault_code != ERR_OK) begin
              // Faults bypass DMEM entirely; the DMEM-side registers keep
              // their previous contents.
              rsp_valid_reg <= 1'b1;
              rsp_rdata_reg <= '0;
              rsp_err_reg   <= fault_code;
              state_reg     <= RESP;
            end else begin
              dmem_rden_reg     <= ~REQ_WE;
              dmem_wen_reg      <= REQ_WE;
              dmem_byte_sel_reg <= REQ_SIZE;
              dmem_sign_reg     <= REQ_SIGN;
              dmem_addr_reg     <= addr_issue;
              dmem_wdata_reg    <= REQ_WDATA;
              state_reg         <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (we_reg) begin
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= ERR_OK;
            state_reg     <= RESP;
          end else begin
            state_reg <= WAIT;
          end
        end

        WAIT: begin
          // DMEM registered the read on the edge that ended ISSUE, so its
          // data is present during this cycle.
          rsp_valid_reg <= 1'b1;
          rsp_rdata_reg <= DMEM_RDATA;
          rsp_err_reg   <= ERR_OK;
          state_reg     <= RESP;
        end

        RESP: begin
          if (RSP_READY) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Ready is gated by the reset input so that no request is acknowledged
  // while reset is being applied.
  assign REQ_READY     = RST_N && (state_reg == IDLE);

  assign RSP_VALID     = rsp_valid_reg;
  assign RSP_RDATA     = rsp_rdata_reg;
  assign RSP_ERR       = rsp_err_reg;
  assign DMEM_RDEN     = dmem_rden_reg;
  assign DMEM_WEN      = dmem_wen_reg;
  assign DMEM_BYTE_SEL = dmem_byte_sel_reg;
  assign DMEM_SIGN     = dmem_sign_reg;
  assign DMEM_ADDR     = dmem_addr_reg;
  assign DMEM_WDATA    = dmem_wdata_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
//
// Directed testbench for lsu_ctrl. Each stimulus call first queues the
// expected DMEM strobe (if any) and the expected response. A monitor running
// on the falling clock edge compares each DMEM strobe and each response cycle
// against the head of those queues. It also measures strobe and response
// latency, counted in cycles from the accepting edge.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  localparam int ADDR_W = 14;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic              REQ_WE = 1'b0;
  logic [1:0]        REQ_SIZE = 2'b00;
  logic              REQ_SIGN = 1'b0;
  logic [31:0]       REQ_ADDR = '0;
  logic [31:0]       REQ_WDATA = '0;
  logic              RSP_VALID;
  logic              RSP_READY = 1'b1;
  logic [31:0]       RSP_RDATA;
  logic [1:0]        RSP_ERR;
  logic              DMEM_RDEN;
  logic              DMEM_WEN;
  logic [1:0]        DMEM_BYTE_SEL;
  logic              DMEM_SIGN;
  logic [ADDR_W-1:0] DMEM_ADDR;
  logic [31:0]       DMEM_WDATA;
  logic [31:0]       DMEM_RDATA = '0;

  always #5 CLK = ~CLK;

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .REQ_VALID     (REQ_VALID),
    .REQ_READY     (REQ_READY),
    .REQ_WE        (REQ_WE),
    .REQ_SIZE      (REQ_SIZE),
    .REQ_SIGN      (REQ_SIGN),
    .REQ_ADDR      (REQ_ADDR),
    .REQ_WDATA     (REQ_WDATA),
    .RSP_VALID     (RSP_VALID),
    .RSP_READY     (RSP_READY),
    .RSP_RDATA     (RSP_RDATA),
    .RSP_ERR       (RSP_ERR),
    .DMEM_RDEN     (DMEM_RDEN),
    .DMEM_WEN      (DMEM_WEN),
    .DMEM_BYTE_SEL (DMEM_BYTE_SEL),
    .DMEM_SIGN     (DMEM_SIGN),
    .DMEM_ADDR     (DMEM_ADDR),
    .DMEM_WDATA    (DMEM_WDATA),
    .DMEM_RDATA    (DMEM_RDATA)
  );

  // Simple word-wide DMEM model with a registered read port.
  logic [31:0] mem [0:15];
  always @(posedge CLK) begin
    if (DMEM_WEN)  mem[DMEM_ADDR[5:2]] <= DMEM_WDATA;
    if (DMEM_RDEN) DMEM_RDATA <= mem[DMEM_ADDR[5:2]];
  end

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } stb_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [31:0] lat;
  } rsp_t;

  stb_t stb_q[$];
  rsp_t rsp_q[$];
  stb_t s_cur;
  rsp_t r_cur;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  int  cyc = 0;
  int  acc_cyc = 0;
  logic rsp_seen = 1'b0;

  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      rsp_seen = 1'b0;
    end else begin
      if (DMEM_RDEN || DMEM_WEN) begin
        checks++;
        if (stb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got rden=%0b wen=%0b addr=0x%04h required no strobe",
                   DMEM_RDEN, DMEM_WEN, DMEM_ADDR);
        end else begin
          s_cur = stb_q.pop_front();
          chk("stb_wen",      32'(DMEM_WEN),      32'(s_cur.we));
          chk("stb_rden",     32'(DMEM_RDEN),     32'(!s_cur.we));
          chk("stb_byte_sel", 32'(DMEM_BYTE_SEL), 32'(s_cur.size));
          chk("stb_sign",     32'(DMEM_SIGN),     32'(s_cur.sign));
          chk("stb_addr",     32'(DMEM_ADDR),     32'(s_cur.addr));
          chk("stb_wdata",    DMEM_WDATA,         s_cur.wdata);
          chk("stb_latency",  32'(cyc - acc_cyc), 32'd1);
        end
      end
      if (RSP_VALID) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata=0x%08h err=%0b required no response",
                   RSP_RDATA, RSP_ERR);
        end else begin
          r_cur = rsp_q[0];
          if (!rsp_seen) begin
            rsp_seen = 1'b1;
            chk("rsp_latency", 32'(cyc - acc_cyc), r_cur.lat);
          end
          chk("rsp_rdata", RSP_RDATA,     r_cur.rdata);
          chk("rsp_err",   32'(RSP_ERR),  32'(r_cur.err));
          if (RSP_READY) begin
            void'(rsp_q.pop_front());
            rsp_seen = 1'b0;
            $display("rsp done: rdata=0x%08h err=%0b", RSP_RDATA, RSP_ERR);
          end
        end
      end
      // Accept happens on the next rising edge; latencies count from here.
      if (REQ_VALID && REQ_READY) acc_cyc = cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic exp_stb(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
    stb_t s;
    s.we = we; s.size = size; s.sign = sign; s.addr = addr[ADDR_W-1:0]; s.wdata = wdata;
    stb_q.push_back(s);
  endtask

  task automatic exp_rsp(input logic [31:0] rdata, input logic [1:0] err, input int lat);
    rsp_t r;
    r.rdata = rdata; r.err = err; r.lat = 32'(lat);
    rsp_q.push_back(r);
  endtask

  // Presents one request, waits for acceptance, then scrambles REQ_* so any
  // dependence on post-acceptance inputs shows up as a mismatch.
  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int t;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = size; REQ_SIGN = sign;
    REQ_ADDR = addr; REQ_WDATA = wdata;
    $display("req: we=%0b size=%0b sign=%0b addr=0x%08h wdata=0x%08h", we, size, sign, addr, wdata);
    t = 0;
    while (!REQ_READY && t < 20) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("req_accept", 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_WE = ~we; REQ_SIZE = 2'b11; REQ_SIGN = ~sign;
    REQ_ADDR = 32'hffff_ffff; REQ_WDATA = ~wdata;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || stb_q.size() != 0) && t < 50) begin
      @(posedge CLK);
      t++;
    end
    #1;
    chk(name, 32'(rsp_q.size() + stb_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t;

    // Reset held for three edges.
    RST_N = 1'b0;
    RSP_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready",  32'(REQ_READY),     32'd0);
    chk("rst_rsp_valid",  32'(RSP_VALID),     32'd0);
    chk("rst_rsp_rdata",  RSP_RDATA,          32'd0);
    chk("rst_rsp_err",    32'(RSP_ERR),       32'd0);
    chk("rst_rden",       32'(DMEM_RDEN),     32'd0);
    chk("rst_wen",        32'(DMEM_WEN),      32'd0);
    chk("rst_byte_sel",   32'(DMEM_BYTE_SEL), 32'd0);
    chk("rst_sign",       32'(DMEM_SIGN),     32'd0);
    chk("rst_addr",       32'(DMEM_ADDR),     32'd0);
    chk("rst_wdata",      DMEM_WDATA,         32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    #1;
    chk("rel_req_ready", 32'(REQ_READY), 32'd1);

    // Store word, then load it back.
    exp_stb(1'b1, 2'b10, 1'b0, 32'h0, 32'hdeadbeef);
    exp_rsp(32'h0, 2'b00, 2);
    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'hdeadbeef);
    drain("drain_store_w0");

    exp_stb(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    exp_rsp(32'hdeadbeef, 2'b00, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drain("drain_load_w0");

    // Half load with sign from 0x8, response back-pressured for four cycles.
    exp_stb(1'b1, 2'b10, 1'b0, 32'h8, 32'hffffbeef);
    exp_rsp(32'h0, 2'b00, 2);
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hffffbeef);
    drain("drain_store_w8");

    RSP_READY = 1'b0;
    exp_stb(1'b0, 2'b01, 1'b1, 32'h8, 32'h0);
    exp_rsp(32'hffffbeef, 2'b00, 3);
    issue(1'b0, 2'b01, 1'b1, 32'h8, 32'h0);
    t = 0;
    while (!RSP_VALID && t < 10) begin
      @(negedge CLK);
      t++;
    end
    repeat (4) begin
      @(negedge CLK);
      chk("stall_rsp_valid", 32'(RSP_VALID), 32'd1);
      chk("stall_req_ready", 32'(REQ_READY), 32'd0);
    end
    @(posedge CLK); #1;
    RSP_READY = 1'b1;
    drain("drain_stall_half");

    // Word load at 0x1 and half store at 0x5: misaligned.
`ifdef LSU_MISALIGN_TRAP_EN
    exp_rsp(32'h0, 2'b01, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h1, 32'h0);
    drain("drain_mis_load");
    exp_rsp(32'h0, 2'b01, 1);
    issue(1'b1, 2'b01, 1'b0, 32'h5, 32'h0000_1234);
    drain("drain_mis_store");
`else
    exp_stb(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    exp_rsp(32'hdeadbeef, 2'b00, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h1, 32'h0);
    drain("drain_mis_load");
    exp_stb(1'b1, 2'b01, 1'b0, 32'h4, 32'h0000_1234);
    exp_rsp(32'h0, 2'b00, 2);
    issue(1'b1, 2'b01, 1'b0, 32'h5, 32'h0000_1234);
    drain("drain_mis_store");
`endif

    // Byte access at an odd address is always legal.
    exp_stb(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
    exp_rsp(32'hdeadbeef, 2'b00, 3);
    issue(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
    drain("drain_byte_odd");

    // Size and range faults, with size taking priority.
    exp_rsp(32'h0, 2'b11, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0);
    drain("drain_size_fault");
    exp_rsp(32'h0, 2'b10, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
    drain("drain_range_fault");
    exp_rsp(32'h0, 2'b11, 1);
    issue(1'b1, 2'b11, 1'b0, 32'h1, 32'h5555_aaaa);
    drain("drain_size_store");

    // Highest in-range word.
    exp_stb(1'b1, 2'b10, 1'b0, 32'h3ffc, 32'h0bad_f00d);
    exp_rsp(32'h0, 2'b00, 2);
    issue(1'b1, 2'b10, 1'b0, 32'h3ffc, 32'h0bad_f00d);
    drain("drain_top_store");

    // Reset while waiting for load data: no response may follow.
    exp_stb(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    chk("rstw_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rstw_rden",      32'(DMEM_RDEN), 32'd0);
    chk("rstw_req_ready", 32'(REQ_READY), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    #1;
    chk("rstw_idle", 32'(REQ_READY), 32'd1);
    repeat (4) begin
      @(negedge CLK);
      chk("rstw_no_rsp", 32'(RSP_VALID), 32'd0);
    end

    // Normal operation resumes after reset.
    exp_stb(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    exp_rsp(32'hdeadbeef, 2'b00, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drain("drain_post_reset");

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion within 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
